// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES controller reader.
//   state_t     : reader FSM states
//   BTN_*       : bit positions of each button in the published word
//   NUM_BUTTONS : width of the button word (one 4021 shift chain)
package nes_pad_pkg;

  localparam int NUM_BUTTONS = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    LOW,
    HIGH,
    DONE
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, forces both flops to RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// Reader side of the NES controller (4021 shift register) link.
// Periodically latches the pad, clocks out 8 serial bits and publishes
// an active-high button word once per complete scan.
//   clk        : system clock
//   reset_n    : asynchronous active-low reset (released synchronously)
//   enable     : 1 = new scans may start on poll ticks
//   pad_data_n : serial data from the pad, active-low, asynchronous
//   pad_latch  : latch strobe to the pad, active-high
//   pad_clk    : serial clock to the pad, idle high
//   buttons    : [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   valid      : one-cycle pulse when buttons updates
//   changed    : one-cycle pulse with valid when the word differs from before
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int POLL_CYCLES  = 833_333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   pad_data_n,
  output logic                   pad_latch,
  output logic                   pad_clk,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   valid,
  output logic                   changed
);

  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W     = $clog2(PHASE_MAX);
  localparam int POLL_W    = $clog2(POLL_CYCLES);
  localparam int IDX_W     = $clog2(NUM_BUTTONS);

  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_FIRST  = IDX_W'(BTN_A);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(BTN_RIGHT);

  logic rst_sync_n;
  logic data_s;

  // Reset asserts asynchronously, releases on a clock edge.
  sync_2ff #(.RST_VAL(1'b0)) u_rst_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  // Idle line reads 1 (pull-up), so reset to 1 to avoid a fake press.
  sync_2ff #(.RST_VAL(1'b1)) u_data_sync (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .d     (pad_data_n),
    .q     (data_s)
  );

  // ---------------- poll timer ----------------
  logic [POLL_W-1:0] timer;
  logic              tick;

  assign tick = (timer == POLL_LAST);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) timer <= '0;
    else             timer <= tick ? '0 : timer + 1'b1;
  end

  // ---------------- FSM ----------------
  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [NUM_BUTTONS-1:0] shift;
  logic               latch_end, half_end;

  assign latch_end = (cnt == LATCH_LAST);
  assign half_end  = (cnt == HALF_LAST);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick && enable) state_nx = LATCH;
      LATCH:   if (latch_end)      state_nx = GAP;
      GAP:     if (half_end)       state_nx = LOW;
      LOW:     if (half_end)       state_nx = HIGH;
      HIGH:    if (half_end)       state_nx = (idx == IDX_LAST) ? DONE : LOW;
      DONE:                        state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free
  // pins yet still line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      buttons   <= '0;
      valid     <= 1'b0;
      changed   <= 1'b0;
    end else begin
      pad_latch <= (state_nx == LATCH);
      pad_clk   <= (state_nx != LOW);
      valid     <= 1'b0;
      changed   <= 1'b0;

      // Phase counter restarts on every state change.
      if (state_nx != state || state == IDLE) cnt <= '0;
      else                                    cnt <= cnt + 1'b1;

      // Sample at the end of the high half, one full half-period after
      // the pad shifted, leaving room for the synchronizer latency.
      if ((state == GAP || state == HIGH) && half_end)
        shift[idx] <= ~data_s;

      if (state == IDLE)
        idx <= IDX_FIRST;
      else if ((state == GAP || state == HIGH) && half_end && idx != IDX_LAST)
        idx <= idx + 1'b1;

      // Whole word published at once; valid/changed line up with it.
      if (state == DONE) begin
        buttons <= shift;
        valid   <= 1'b1;
        changed <= (shift != buttons);
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
module tb_nes_pad_reader;

  localparam int POLL  = 200;
  localparam int LATCH = 6;
  localparam int HALF  = 3;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b1;
  logic       enable    = 1'b0;
  logic       pad_data_n;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       changed;

  // controller model state
  logic [7:0] pressed   = 8'h00;
  logic       unplugged = 1'b0;
  logic [7:0] sr        = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int last_gap = 0;

  typedef struct packed {
    logic [7:0] btn;
    logic       chg;
  } exp_t;
  exp_t sb[$];

  // monitor-owned state
  logic       lat_q    = 1'b0;
  logic       en_q     = 1'b0;
  int         lat_run  = 0;
  int         low_run  = 0;
  int         pulses   = 0;
  int         gap      = 0;
  logic [7:0] exp_prev = 8'h00;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .POLL_CYCLES  (POLL),
    .LATCH_CYCLES (LATCH),
    .HALF_CYCLES  (HALF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pad_data_n (pad_data_n),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .buttons    (buttons),
    .valid      (valid),
    .changed    (changed)
  );

  // 4021-style pad: parallel load while latched, shift on pad_clk rise,
  // zeros shift in behind the last button (reads as "released").
  assign pad_data_n = unplugged ? 1'b1 : ~sr[0];

  initial begin
    forever begin
      @(posedge pad_latch or posedge pad_clk);
      if (pad_latch) sr = pressed;
      else           sr = {1'b0, sr[7:1]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: expected word pushed at each scan start,
  // popped and compared whenever the DUT signals valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      gap++;
      if (!reset_n) begin
        sb.delete();
        exp_prev = 8'h00;
        lat_run  = 0;
        low_run  = 0;
        pulses   = 0;
        lat_q    = 1'b0;
        en_q     = enable;
      end else begin
        if (pad_latch && !lat_q) begin
          check("latch_only_when_enabled", en_q, 1);
          e.btn    = unplugged ? 8'h00 : pressed;
          e.chg    = (e.btn != exp_prev);
          exp_prev = e.btn;
          sb.push_back(e);
          pulses   = 0;
        end
        if (pad_latch) lat_run++;
        else if (lat_run != 0) begin
          check("latch_width", lat_run, LATCH);
          lat_run = 0;
        end
        if (!pad_clk) low_run++;
        else if (low_run != 0) begin
          check("clk_low_width", low_run, HALF);
          pulses++;
          low_run = 0;
        end
        check("changed_only_with_valid", changed & ~valid, 0);
        if (valid) begin
          check("valid_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("buttons", buttons, e.btn);
            check("changed", changed, e.chg);
            check("clk_pulses", pulses, 7);
          end
          last_gap = gap;
          gap      = 0;
        end
        lat_q = pad_latch;
        en_q  = enable;
      end
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!valid && n < 450) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_seen"}, valid, 1);
    #1;
  endtask

  task automatic wait_latch(input string name);
    int n = 0;
    @(negedge clk);
    while (!pad_latch && n < 260) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latch_seen"}, pad_latch, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   falls;
    int   rises;
    int   n;
    logic prevc;
    logic prevl;

    #1 reset_n = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pad_latch", pad_latch, 0);
    check("rst_pad_clk",   pad_clk,   1);
    check("rst_buttons",   buttons,   0);
    check("rst_valid",     valid,     0);
    check("rst_changed",   changed,   0);

    @(posedge clk); #2;
    reset_n = 1'b1;
    enable  = 1'b1;
    pressed = 8'h09;

    // 1/2: A|Start, then the same again
    wait_valid("t1");
    wait_valid("t2");

    // 3: bit order patterns, then random words
    pressed = 8'h80;
    wait_valid("t3_right");
    pressed = 8'hAA;
    wait_valid("t3_aa");
    for (int i = 0; i < 6; i++) begin
      pressed = 8'($urandom_range(0, 255));
      wait_valid("t3_rand");
    end

    // 4: drop enable during bit 3
    pressed = 8'h5A;
    wait_latch("t4");
    falls = 0; n = 0; prevc = pad_clk;
    while (falls < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (!pad_clk && prevc) falls++;
      prevc = pad_clk;
    end
    check("t4_bit3_reached", falls, 3);
    @(posedge clk); #2;
    enable = 1'b0;
    wait_valid("t4_publish");
    rises = 0; prevl = pad_latch;
    repeat (450) begin
      @(negedge clk);
      if (pad_latch && !prevl) rises++;
      prevl = pad_latch;
    end
    check("t4_no_scan_disabled", rises, 0);
    pressed = 8'h33;
    @(posedge clk); #2;
    enable = 1'b1;
    wait_latch("t4_resume");
    wait_valid("t4_resume");

    // 5: reset in the middle of a LOW phase
    pressed = 8'hFF;
    n = 0;
    @(negedge clk);
    while (pad_clk && n < 260) begin
      @(negedge clk);
      n++;
    end
    check("t5_low_seen", pad_clk, 0);
    #1 reset_n = 1'b0;
    #1;
    check("t5_pad_clk",   pad_clk,   1);
    check("t5_pad_latch", pad_latch, 0);
    check("t5_buttons",   buttons,   0);
    check("t5_valid",     valid,     0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b1;
    wait_valid("t5_rescan");

    // 6: unplugged pad reads as nothing pressed, steady poll period
    unplugged = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_valid("t6");
      check("t6_valid_period", last_gap, POLL);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
